// File: rtl/image_frame_sched_pkg.sv
// Shared definitions for the image frame scheduler and the frame read/write models.
// IMG_SCHED_BOTTOM_UP_EN selects bottom-up (BMP order) row addressing.
package image_frame_sched_pkg;

    localparam int unsigned IMG_WIDTH  = 768;
    localparam int unsigned IMG_HEIGHT = 512;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VSYNC  = 3'd1;
    localparam state_t ST_LINE   = 3'd2;
    localparam state_t ST_HBLANK = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Pixel-pair address for the default image geometry.
    function automatic int unsigned pair_addr(input int unsigned row, input int unsigned pair);
`ifdef IMG_SCHED_BOTTOM_UP_EN
        return (IMG_HEIGHT - 1 - row) * (IMG_WIDTH / 2) + pair;
`else
        return row * (IMG_WIDTH / 2) + pair;
`endif
    endfunction

endpackage

// File: rtl/image_frame_sched_addr_gen.sv
// Row/pair counters with multiply-free pair-address accumulation.
// IMG_SCHED_BOTTOM_UP_EN starts at the last row and steps the line base downward.
module img_addr_gen
    import image_frame_sched_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT,
    parameter int unsigned AW     = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic [15:0]   row,
    output logic          last_pair,
    output logic          last_row
);

    localparam int unsigned   HALF   = WIDTH / 2;
    localparam logic [AW-1:0] HALF_A = AW'(HALF);
`ifdef IMG_SCHED_BOTTOM_UP_EN
    localparam logic [AW-1:0] BASE0  = AW'((HEIGHT - 1) * HALF);
`else
    localparam logic [AW-1:0] BASE0  = '0;
`endif

    logic [15:0]   pair;
    logic [AW-1:0] base;

    assign addr      = base + AW'(pair);
    assign last_pair = (pair == 16'(HALF - 1));
    assign last_row  = (row == 16'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pair <= '0;
            row  <= '0;
            base <= BASE0;
        end else if (clear) begin
            pair <= '0;
            row  <= '0;
            base <= BASE0;
        end else if (step) begin
            if (last_pair) begin
                pair <= '0;
                // Hold on the final row so nothing wraps before the next clear.
                if (!last_row) begin
                    row <= row + 16'd1;
`ifdef IMG_SCHED_BOTTOM_UP_EN
                    base <= base - HALF_A;
`else
                    base <= base + HALF_A;
`endif
                end
            end else begin
                pair <= pair + 16'd1;
            end
        end
    end

endmodule

// File: rtl/image_frame_sched.sv
// Frame scheduler: V_sync lead-in, pixel-pair reads with line blanking and backpressure.
// IMG_SCHED_BOTTOM_UP_EN (see img_addr_gen) selects bottom-up row addressing.
//
// state  | meaning
// IDLE   | waiting for start
// VSYNC  | V_sync lead-in, VS_LEN cycles
// LINE   | one pair read per cycle while out_ready
// HBLANK | HB_LEN idle cycles between lines
// DONE   | drain last H_sync, then one-cycle done pulse
module image_frame_sched
    import image_frame_sched_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT,
    parameter int unsigned VS_LEN = 16,
    parameter int unsigned HB_LEN = 4,
    parameter int unsigned AW     = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          out_ready,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          V_sync,
    output logic          H_sync,
    output logic [15:0]   line_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [15:0] VS_LOAD = 16'(VS_LEN - 1);
    localparam logic [15:0] HB_LOAD = 16'(HB_LEN - 1);

    state_t        state;
    logic [15:0]   timer;
    logic          timer_tc;
    logic          start_ok;
    logic          abort_ok;
    logic [AW-1:0] addr;
    logic [15:0]   row;
    logic          last_pair;
    logic          last_row;

    assign timer_tc = (timer == 16'd0);
    assign start_ok = (state == ST_IDLE) && start;
    assign abort_ok = (state != ST_IDLE) && abort;

    assign rd_en   = (state == ST_LINE) && out_ready;
    assign rd_addr = rd_en ? addr : '0;
    assign V_sync  = (state == ST_VSYNC);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE) && timer_tc;

    img_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .AW     (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok || abort_ok),
        .step      (rd_en),
        .addr      (addr),
        .row       (row),
        .last_pair (last_pair),
        .last_row  (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            H_sync   <= 1'b0;
            line_idx <= '0;
        end else begin
            // One-cycle memory latency: data for a read shows up with H_sync.
            H_sync   <= rd_en;
            line_idx <= row;
            if (abort_ok) begin
                state <= ST_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_VSYNC;
                            timer <= VS_LOAD;
                        end
                    end
                    ST_VSYNC: begin
                        if (timer_tc) state <= ST_LINE;
                        else          timer <= timer - 16'd1;
                    end
                    ST_LINE: begin
                        if (out_ready && last_pair) begin
                            if (last_row) begin
                                state <= ST_DONE;
                                timer <= 16'd1;
                            end else if (HB_LEN != 0) begin
                                state <= ST_HBLANK;
                                timer <= HB_LOAD;
                            end
                        end
                    end
                    ST_HBLANK: begin
                        if (timer_tc) state <= ST_LINE;
                        else          timer <= timer - 16'd1;
                    end
                    ST_DONE: begin
                        if (timer_tc) state <= ST_IDLE;
                        else          timer <= timer - 16'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_frame_sched.sv
// Self-checking bench for image_frame_sched on an 8x4 image with randomized backpressure.
module tb_image_frame_sched;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int VS   = 3;
    localparam int HB   = 2;
    localparam int AW   = 18;
    localparam int HALF = W / 2;
    localparam int NRD  = W * H / 2;
    localparam int FLEN = VS + NRD + (H - 1) * HB + 2;

    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic          rd_en, V_sync, H_sync, busy, done;
    logic [AW-1:0] rd_addr;
    logic [15:0]   line_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int q_addr[$];
    int q_line[$];
    int q_hcyc[$];
    int done_cnt, done_cyc, vs_cnt, vs_first, bad_rd;
    bit rand_en = 1'b0;

    image_frame_sched #(
        .WIDTH(W), .HEIGHT(H), .VS_LEN(VS), .HB_LEN(HB), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .V_sync(V_sync), .H_sync(H_sync),
        .line_idx(line_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rd_en) begin
            q_addr.push_back(int'(rd_addr));
            if (!out_ready) bad_rd++;
        end
        if (H_sync) begin
            q_line.push_back(int'(line_idx));
            q_hcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (V_sync) begin
            if (vs_cnt == 0) vs_first = cyc;
            vs_cnt++;
        end
    end

    // Reference: the i-th read of a frame is (row = i / HALF, pair = i % HALF).
    function automatic int exp_addr(input int i);
        int r, p;
        r = i / HALF;
        p = i % HALF;
`ifdef IMG_SCHED_BOTTOM_UP_EN
        return (H - 1 - r) * HALF + p;
`else
        return r * HALF + p;
`endif
    endfunction

    function automatic int addr_errs();
        int e = 0;
        foreach (q_addr[i]) if (q_addr[i] != exp_addr(i)) e++;
        return e;
    endfunction

    function automatic int line_errs();
        int e = 0;
        foreach (q_line[i]) if (q_line[i] != i / HALF) e++;
        return e;
    endfunction

    task automatic clear_mon();
        q_addr.delete();
        q_line.delete();
        q_hcyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        vs_cnt   = 0;
        vs_first = -1;
        bad_rd   = 0;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1 start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, V_sync, H_sync, line_idx, busy, done} !== '0)
            $display("FAIL reset_outputs: got rd_en=%b addr=%0d vs=%b hs=%b line=%0d busy=%b done=%b, want all 0",
                     rd_en, rd_addr, V_sync, H_sync, line_idx, busy, done);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int t0;
        clear_mon();
        pulse_start(t0);
        wait_done(200);
        n_checks++;
        if (vs_cnt != VS || vs_first != t0 + 1)
            $display("FAIL basic_vsync: got %0d cycles from %0d, want %0d from %0d", vs_cnt, vs_first, VS, t0 + 1);
        else n_pass++;
        n_checks++;
        if (q_addr.size() != NRD || addr_errs() != 0)
            $display("FAIL basic_addr: got %0d reads %0d bad, want %0d reads 0 bad", q_addr.size(), addr_errs(), NRD);
        else n_pass++;
        n_checks++;
        if (q_line.size() != NRD || line_errs() != 0)
            $display("FAIL basic_line_idx: got %0d pairs %0d bad, want %0d pairs 0 bad", q_line.size(), line_errs(), NRD);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || done_cyc != t0 + FLEN)
            $display("FAIL basic_done: got %0d pulses at %0d, want 1 at %0d", done_cnt, done_cyc, t0 + FLEN);
        else n_pass++;
        n_checks++;
        if (q_hcyc.size() == 0 || q_hcyc[$] + 1 != done_cyc)
            $display("FAIL basic_done_after_hsync: got done %0d, want one cycle after last H_sync", done_cyc);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int t0;
        clear_mon();
        pulse_start(t0);
        // Line 1 begins at t0+VS+1+HALF+HB; stall its cycles 2..4.
        while (cyc < t0 + VS + 1 + HALF + HB + 2 - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(200);
        n_checks++;
        if (bad_rd != 0) $display("FAIL bp_rd_when_stalled: got %0d reads, want 0", bad_rd);
        else n_pass++;
        n_checks++;
        if (q_addr.size() != NRD || addr_errs() != 0)
            $display("FAIL bp_addr: got %0d reads %0d bad, want %0d reads 0 bad", q_addr.size(), addr_errs(), NRD);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || done_cyc != t0 + FLEN + 3)
            $display("FAIL bp_done: got %0d pulses at %0d, want 1 at %0d", done_cnt, done_cyc, t0 + FLEN + 3);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        int t0;
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            pulse_start(t0);
            rand_en = 1'b1;
            wait_done(400);
            rand_en = 1'b0;
            #2 out_ready = 1'b1;
            n_checks++;
            if (q_addr.size() != NRD || addr_errs() != 0 || line_errs() != 0 || bad_rd != 0)
                $display("FAIL rand_stream%0d: got %0d reads %0d bad addr %0d bad line %0d stalled reads, want %0d clean",
                         f, q_addr.size(), addr_errs(), line_errs(), bad_rd, NRD);
            else n_pass++;
            n_checks++;
            if (done_cnt != 1 || q_hcyc.size() == 0 || done_cyc != q_hcyc[$] + 1)
                $display("FAIL rand_done%0d: got %0d pulses at %0d, want 1 right after last H_sync", f, done_cnt, done_cyc);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int t0, a, trail;
        clear_mon();
        pulse_start(t0);
        while (q_addr.size() < 2 * HALF + 1 && cyc < t0 + 100) begin @(posedge clk); #1; end
        @(posedge clk); #1 abort = 1'b1;
        a = cyc;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0)
            $display("FAIL abort_idle: got busy=%b rd_en=%b, want 0 0", busy, rd_en);
        else n_pass++;
        repeat (40) @(posedge clk);
        #1;
        trail = 0;
        foreach (q_hcyc[i]) if (q_hcyc[i] > a) trail++;
        n_checks++;
        if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses, want 0", done_cnt);
        else n_pass++;
        n_checks++;
        if (trail > 1 || addr_errs() != 0)
            $display("FAIL abort_trailing: got %0d trailing H_sync %0d bad addr, want <=1 and 0", trail, addr_errs());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        clear_mon();
        pulse_start(t0);
        while (cyc < t0 + VS + 1 + HALF) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, V_sync, H_sync, line_idx, busy, done} !== '0)
            $display("FAIL midreset_outputs: got rd_en=%b addr=%0d vs=%b hs=%b line=%0d busy=%b done=%b, want all 0",
                     rd_en, rd_addr, V_sync, H_sync, line_idx, busy, done);
        else n_pass++;
        clear_mon();
        pulse_start(t0);
        wait_done(200);
        n_checks++;
        if (q_addr.size() != NRD || addr_errs() != 0 || done_cnt != 1 || done_cyc != t0 + FLEN)
            $display("FAIL midreset_clean_frame: got %0d reads %0d bad done %0d at %0d, want %0d clean done 1 at %0d",
                     q_addr.size(), addr_errs(), done_cnt, done_cyc, NRD, t0 + FLEN);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        int t0;
        clear_mon();
        pulse_start(t0);
        while (cyc < t0 + VS + 2) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < t0 + FLEN) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ignstart_done_cycle: got busy=%b, want 0", busy);
        else n_pass++;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (q_addr.size() != NRD || addr_errs() != 0 || done_cnt != 1 || vs_cnt != VS)
            $display("FAIL ignstart_frame: got %0d reads done %0d vs %0d, want %0d done 1 vs %0d",
                     q_addr.size(), done_cnt, vs_cnt, NRD, VS);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_mon();
        pulse_start(t0);
        while (done_cnt == 0 && cyc < t0 + 200) begin @(posedge clk); #1; end
        // Now in the cycle after done: first IDLE cycle.
        start = 1'b1;
        t1 = cyc;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (V_sync !== 1'b1 || t1 != t0 + FLEN + 1)
            $display("FAIL b2b_accept: got V_sync=%b start at %0d, want 1 at %0d", V_sync, t1, t0 + FLEN + 1);
        else n_pass++;
        clear_mon();
        wait_done(200);
        n_checks++;
        if (q_addr.size() != NRD || addr_errs() != 0 || done_cyc != t1 + FLEN)
            $display("FAIL b2b_frame: got %0d reads %0d bad done at %0d, want %0d clean done at %0d",
                     q_addr.size(), addr_errs(), done_cyc, NRD, t1 + FLEN);
        else n_pass++;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_reset_mid_frame();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
